// File: rtl/ascii_case_converter_if.sv
// Character stream bundle between a source, the case converter and a sink.
// The slave modport is the converter's view; the master modport is the source/sink side.
interface ascii_case_converter_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;

    modport master (
        output in_valid,
        output in_char,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_char
    );

    modport slave (
        input  in_valid,
        input  in_char,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_char
    );
endinterface

// File: rtl/ascii_case_converter.sv
// Streaming ASCII case converter: converts each accepted character by the per-character mode,
// buffers it in a circular FIFO and counts (saturating) the characters whose value changed.
module ascii_case_converter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ascii_case_converter_if.slave    bus,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     count_clr,
    output logic [CNT_W-1:0]         conv_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic       in_ready_int;
    logic       out_valid_int;
    logic       push;
    logic       pop;
    logic       is_lower;
    logic       is_upper;
    logic       flip;
    logic [7:0] conv_char;
    logic       altered;

    // Mode bit 0 enables lower->upper, bit 1 enables upper->lower; toggle sets both.
    always_comb begin
        is_lower  = (bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A);
        is_upper  = (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A);
        flip      = (is_lower && bus.mode[0]) || (is_upper && bus.mode[1]);
        conv_char = flip ? (bus.in_char ^ 8'h20) : bus.in_char;
        altered   = (conv_char != bus.in_char);
    end

    // Readiness looks only at the stored level, so a full FIFO never takes a char while popping.
    assign in_ready_int  = (level_q < FULL_LEVEL) && !rst;
    assign out_valid_int = (level_q != '0);
    assign push          = bus.in_valid && in_ready_int;
    assign pop           = out_valid_int && bus.out_ready;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_char  = mem_q[rd_ptr_q];
    assign level         = level_q;
    assign conv_count    = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = conv_char;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (push && altered && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_ascii_case_converter.sv
// Testbench for ascii_case_converter: scenario tasks with inline checks and a queue
// of expected output characters filled on accept and drained on each transfer out.
module tb_ascii_case_converter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             count_clr = 1'b0;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] conv_count;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];

    ascii_case_converter_if bus ();

    ascii_case_converter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .level      (level),
        .count_clr  (count_clr),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    // Reference conversion written from the character ranges, independent of the RTL's XOR form.
    function automatic logic [7:0] model_conv(input logic [7:0] c, input logic [1:0] m);
        if (c >= 8'h61 && c <= 8'h7A && (m == 2'b01 || m == 2'b11)) return c - 8'h20;
        if (c >= 8'h41 && c <= 8'h5A && (m == 2'b10 || m == 2'b11)) return c + 8'h20;
        return c;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [1:0] m);
        bus.in_valid = v;
        bus.in_char  = c;
        bus.mode     = m;
    endtask

    // Handshakes are judged at the falling edge, ahead of the rising edge that performs them.
    task automatic advance_cycle();
        logic [7:0] e;
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL scoreboard_pop: out_char=%02h popped, required no pending char", bus.out_char);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_char !== e) begin
                    n_bad++;
                    $display("[TB] FAIL scoreboard_char: got %02h, required %02h", bus.out_char, e);
                end
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(model_conv(bus.in_char, bus.mode));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        count_clr = 1'b1;
        applyStimulus(1'b0, 8'h00, 2'b00);
        advance_cycle();
        count_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        count_clr = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %0b, required 0", bus.in_ready); end
        n_cmp++; if (level !== 0) begin n_bad++; $display("[TB] FAIL reset_level: got %0d, required 0", level); end
        n_cmp++; if (conv_count !== 0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d, required 0", conv_count); end
        n_cmp++; if (bus.out_char !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_out_char: got %02h, required 00", bus.out_char); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL release_in_ready: got %0b, required 1", bus.in_ready); end
        exp_q.delete();
    endtask

    task automatic test_upper_stream();
        logic [7:0] ins  [6] = '{8'h61, 8'h62, 8'h63, 8'h65, 8'h67, 8'h69};
        logic [7:0] outs [6] = '{8'h41, 8'h42, 8'h43, 8'h45, 8'h47, 8'h49};
        clear_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, ins[i], 2'b01);
            advance_cycle();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== outs[i] || level !== 1) begin
                n_bad++;
                $display("[TB] FAIL upper_latency[%0d]: got valid=%0b char=%02h level=%0d, required 1/%02h/1",
                         i, bus.out_valid, bus.out_char, level, outs[i]);
            end
        end
        applyStimulus(1'b0, 8'h00, 2'b01);
        advance_cycle();
        n_cmp++; if (conv_count !== 6) begin n_bad++; $display("[TB] FAIL upper_count: got %0d, required 6", conv_count); end
        n_cmp++; if (level !== 0) begin n_bad++; $display("[TB] FAIL upper_drain_level: got %0d, required 0", level); end
    endtask

    task automatic test_boundaries();
        logic [7:0] ins  [9] = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'hE1};
        logic [7:0] outs [9] = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h60, 8'h41, 8'h5A, 8'h7B, 8'hE1};
        clear_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, ins[i], 2'b11);
            advance_cycle();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== outs[i]) begin
                n_bad++;
                $display("[TB] FAIL boundary[%0d] in=%02h: got valid=%0b char=%02h, required 1/%02h",
                         i, ins[i], bus.out_valid, bus.out_char, outs[i]);
            end
        end
        applyStimulus(1'b0, 8'h00, 2'b11);
        advance_cycle();
        n_cmp++; if (conv_count !== 4) begin n_bad++; $display("[TB] FAIL boundary_count: got %0d, required 4", conv_count); end
    endtask

    task automatic test_mode_switch();
        logic [7:0] ins   [4] = '{8'h61, 8'h61, 8'h41, 8'h41};
        logic [1:0] modes [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [7:0] outs  [4] = '{8'h61, 8'h41, 8'h61, 8'h41};
        clear_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ins[i], modes[i]);
            advance_cycle();
            n_cmp++;
            if (bus.out_char !== outs[i]) begin
                n_bad++;
                $display("[TB] FAIL mode_switch[%0d]: got %02h, required %02h", i, bus.out_char, outs[i]);
            end
        end
        applyStimulus(1'b0, 8'h00, 2'b00);
        advance_cycle();
        n_cmp++; if (conv_count !== 2) begin n_bad++; $display("[TB] FAIL mode_switch_count: got %0d, required 2", conv_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [DEPTH+2];
        int   idx = 0;
        int   guard = 0;
        logic will;
        for (int i = 0; i < DEPTH + 2; i++) vals[i] = 8'h30 + 8'(i);
        clear_count();
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < DEPTH + 2; cyc++) begin
            applyStimulus(1'b1, vals[idx], 2'b00);
            will = bus.in_ready;
            advance_cycle();
            if (will) idx++;
        end
        n_cmp++; if (idx != DEPTH) begin n_bad++; $display("[TB] FAIL bp_accepts: got %0d, required %0d", idx, DEPTH); end
        n_cmp++; if (level !== DEPTH) begin n_bad++; $display("[TB] FAIL bp_level: got %0d, required %0d", level, DEPTH); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_full_pop_in_ready: got %0b, required 0", bus.in_ready); end
        advance_cycle();
        n_cmp++; if (bus.in_ready !== 1'b1 || level !== DEPTH - 1) begin
            n_bad++; $display("[TB] FAIL bp_after_pop: got in_ready=%0b level=%0d, required 1/%0d", bus.in_ready, level, DEPTH - 1);
        end
        while (guard < 50 && (idx < DEPTH + 2 || level != 0)) begin
            applyStimulus(idx < DEPTH + 2, vals[(idx < DEPTH + 2) ? idx : 0], 2'b00);
            will = bus.in_valid && bus.in_ready;
            advance_cycle();
            if (will) idx++;
            guard++;
        end
        n_cmp++; if (guard >= 50 || idx != DEPTH + 2) begin n_bad++; $display("[TB] FAIL bp_drain_timeout: got idx=%0d level=%0d, required %0d/0", idx, level, DEPTH + 2); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL bp_pending: got %0d chars outstanding, required 0", exp_q.size()); end
        n_cmp++; if (conv_count !== 0) begin n_bad++; $display("[TB] FAIL bp_count: got %0d, required 0", conv_count); end
    endtask

    task automatic test_saturation();
        clear_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'h61, 2'b01);
            advance_cycle();
        end
        n_cmp++; if (conv_count !== 7) begin n_bad++; $display("[TB] FAIL sat_count: got %0d, required 7", conv_count); end
        count_clr = 1'b1;
        applyStimulus(1'b1, 8'h62, 2'b01);
        advance_cycle();
        count_clr = 1'b0;
        n_cmp++; if (conv_count !== 0) begin n_bad++; $display("[TB] FAIL clr_priority: got %0d, required 0", conv_count); end
        applyStimulus(1'b1, 8'h63, 2'b01);
        advance_cycle();
        n_cmp++; if (conv_count !== 1) begin n_bad++; $display("[TB] FAIL count_after_clr: got %0d, required 1", conv_count); end
        applyStimulus(1'b0, 8'h00, 2'b01);
        advance_cycle();
        n_cmp++; if (level !== 0) begin n_bad++; $display("[TB] FAIL sat_drain_level: got %0d, required 0", level); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] ins [3] = '{8'h78, 8'h79, 8'h7A};
        clear_count();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ins[i], 2'b01);
            advance_cycle();
        end
        applyStimulus(1'b0, 8'h00, 2'b01);
        n_cmp++; if (level !== 3 || conv_count !== 3) begin n_bad++; $display("[TB] FAIL mid_fill: got level=%0d count=%0d, required 3/3", level, conv_count); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || level !== 0 || conv_count !== 0) begin
            n_bad++; $display("[TB] FAIL mid_reset: got valid=%0b level=%0d count=%0d, required 0/0/0", bus.out_valid, level, conv_count);
        end
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_char !== 8'h00) begin
            n_bad++; $display("[TB] FAIL mid_reset_ports: got in_ready=%0b out_char=%02h, required 0/00", bus.in_ready, bus.out_char);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 8'h71, 2'b01);
        advance_cycle();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h51) begin
            n_bad++; $display("[TB] FAIL mid_first_after: got valid=%0b char=%02h, required 1/51", bus.out_valid, bus.out_char);
        end
        applyStimulus(1'b0, 8'h00, 2'b01);
        advance_cycle();
        n_cmp++; if (level !== 0 || exp_q.size() != 0) begin
            n_bad++; $display("[TB] FAIL mid_drain: got level=%0d pending=%0d, required 0/0", level, exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        test_reset();
        test_upper_stream();
        test_boundaries();
        test_mode_switch();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
